// File: rtl/bcd_join.sv
// Sequential BCD-to-binary converter: four latched BCD digits are folded into a
// binary value one digit per clock, most significant first, via acc*10 + digit.
module bcd_join #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       thousands,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [OUT_W-1:0] bin
);

    // 9999 needs 14 bits; narrower results would silently wrap.
    if (OUT_W < 14) begin : g_width_check
        $error("bcd_join: OUT_W must be at least 14");
    end

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]       state;
    logic [1:0]       step;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [3:0]       d_th;
    logic [3:0]       d_hu;
    logic [3:0]       d_te;
    logic [3:0]       d_on;
    logic [3:0]       digit;
    logic             bad_digit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        digit = d_th;
        case (step)
            2'd0:    digit = d_th;
            2'd1:    digit = d_hu;
            2'd2:    digit = d_te;
            default: digit = d_on;
        endcase
    end

    assign bad_digit = (d_th > 4'd9) || (d_hu > 4'd9) || (d_te > 4'd9) || (d_on > 4'd9);

    // Multiply by ten as two shifts; an out-of-range digit is still summed, then discarded.
    assign acc_next = (acc << 3) + (acc << 1) + {{(OUT_W-4){1'b0}}, digit};

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_CALC);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= 2'd0;
            acc   <= '0;
            d_th  <= 4'd0;
            d_hu  <= 4'd0;
            d_te  <= 4'd0;
            d_on  <= 4'd0;
            done  <= 1'b0;
            err   <= 1'b0;
            bin   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d_th  <= thousands;
                        d_hu  <= hundreds;
                        d_te  <= tens;
                        d_on  <= ones;
                        acc   <= '0;
                        step  <= 2'd0;
                        err   <= 1'b0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (step == 2'd3) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                        acc   <= acc_next;
                        if (bad_digit) begin
                            bin <= '0;
                            err <= 1'b1;
                        end else begin
                            bin <= acc_next;
                            err <= 1'b0;
                        end
                    end else begin
                        acc  <= acc_next;
                        step <= step + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_join.sv
// Self-checking bench for bcd_join: directed vector table, multi-cycle corner
// sequences, and randomized digits checked against a decimal-weight model.
module tb_bcd_join;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] bin;

    int          tests;
    int          failed;
    logic [15:0] exp_bin_prev;

    bcd_join #(.OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bin       (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  th;
        logic [3:0]  hu;
        logic [3:0]  te;
        logic [3:0]  on;
        logic [15:0] exp_bin;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Value from decimal weights; any digit above nine forces the error result.
    function automatic void ref_model(input logic [3:0] th, input logic [3:0] hu,
                                      input logic [3:0] te, input logic [3:0] on,
                                      output logic [15:0] b, output logic e);
        int v;
        e = (th > 9) || (hu > 9) || (te > 9) || (on > 9);
        v = int'(th) * 1000 + int'(hu) * 100 + int'(te) * 10 + int'(on);
        b = e ? 16'h0000 : v[15:0];
    endfunction

    task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                              input logic [3:0] te, input logic [3:0] on);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        ones      = on;
    endtask

    task automatic scramble();
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // One full conversion; optional random start pulses while busy.
    task automatic convert(input logic [3:0] th, input logic [3:0] hu,
                           input logic [3:0] te, input logic [3:0] on,
                           input logic [15:0] eb, input logic ee, input bit extra);
        int lat;
        bit ok;
        @(negedge clk);
        check("ready_before_start", ready, 1);
        set_digits(th, hu, te, on);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_cleared_at_accept", err, 0);
        check("bin_held_during_calc", bin, exp_bin_prev);
        lat = 0;
        ok  = 1'b1;
        while (!done && lat < 12) begin
            if (!busy || ready) ok = 1'b0;
            scramble();
            start = extra ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("busy_not_ready_in_calc", ok, 1);
        check("latency", lat, 4);
        check("done", done, 1);
        check("bin", bin, eb);
        check("err", err, ee);
        check("ready_with_done", ready, 1);
        exp_bin_prev = eb;
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("bin_hold", bin, eb);
        check("err_hold", err, ee);
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ndone;
        int          last;
        bit          gap_ok;
        int          wait_cnt;
        logic [3:0]  r_th, r_hu, r_te, r_on;
        logic [15:0] m_bin;
        logic        m_err;

        tests        = 0;
        failed       = 0;
        exp_bin_prev = 16'h0000;

        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 16'h04D2, 1'b0};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0};
        vecs[3] = '{4'd1, 4'hA, 4'd3, 4'd4, 16'h0000, 1'b1};
        vecs[4] = '{4'd0, 4'd0, 4'd5, 4'd9, 16'h003B, 1'b0};
        vecs[5] = '{4'd8, 4'd0, 4'd6, 4'd1, 16'h1F7D, 1'b0};
        vecs[6] = '{4'd0, 4'd0, 4'd0, 4'hF, 16'h0000, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_bin", bin, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            convert(vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].on,
                    vecs[i].exp_bin, vecs[i].exp_err, 1'b0);

        // Start held high: back-to-back every five clocks, digits scrambled while busy.
        @(negedge clk);
        set_digits(4'd2, 4'd0, 4'd1, 4'd5);
        start  = 1'b1;
        ndone  = 0;
        last   = -1;
        gap_ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_bin", bin, 16'h07DF);
                check("b2b_err", err, 0);
                if (last >= 0 && c - last != 5) gap_ok = 1'b0;
                last = c;
                ndone++;
            end
            if (ready) set_digits(4'd2, 4'd0, 4'd1, 4'd5);
            else scramble();
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 3);
        check("b2b_period", gap_ok, 1);
        wait_cnt = 0;
        while (!done && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("b2b_drain_done", done, 1);
        check("b2b_drain_bin", bin, 16'h07DF);
        exp_bin_prev = 16'h07DF;
        @(negedge clk);

        // Reset during the second CALC cycle aborts the conversion.
        set_digits(4'd5, 4'd0, 4'd0, 4'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_bin", bin, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        exp_bin_prev = 16'h0000;
        convert(4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0, 1'b0);

        // Extra start pulses while busy must be ignored.
        convert(4'd3, 4'd1, 4'd4, 4'd1, 16'h0C45, 1'b0, 1'b1);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("extra_start_no_second_done", ndone, 0);
        check("extra_start_bin_hold", bin, 16'h0C45);

        for (int i = 0; i < 30; i++) begin
            r_th = 4'($urandom_range(0, 9));
            r_hu = 4'($urandom_range(0, 9));
            r_te = 4'($urandom_range(0, 9));
            r_on = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r_th = 4'($urandom_range(10, 15));
                    1:       r_hu = 4'($urandom_range(10, 15));
                    2:       r_te = 4'($urandom_range(10, 15));
                    default: r_on = 4'($urandom_range(10, 15));
                endcase
            end
            ref_model(r_th, r_hu, r_te, r_on, m_bin, m_err);
            convert(r_th, r_hu, r_te, r_on, m_bin, m_err, 1'(i % 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bcd_join.md
Name: bcd_join

Overview:
- Sequential BCD-to-binary converter: the inverse of the binary-to-BCD digit splitter used by the clock display path.
- Takes four BCD digits (thousands, hundreds, tens, ones), for example from set-time buttons or digit counters.
- Produces the equivalent unsigned binary value for the clock/alarm arithmetic.
- Iterative multiply-by-10 accumulate, most significant digit first, with a start/done handshake and an invalid-digit flag.

Parameters:
- OUT_W, 16, width of the binary result. Must be >= 14 so that 9999 fits; synthesis-time check only.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only when ready=1.
- thousands  input  4  BCD digit, weight 1000.
- hundreds  input  4  BCD digit, weight 100.
- tens  input  4  BCD digit, weight 10.
- ones  input  4  BCD digit, weight 1.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- err  output  1  set with done if any latched digit > 9; held until the next accepted start.
- bin  output  OUT_W  binary result; held stable between done pulses.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - outputs: ready=1, busy=0, done=0, err=0, bin=0;
  - internal: state=IDLE, acc=0, step=0, digit latches=0.
- States: IDLE, CALC. ready = (state==IDLE); busy = (state==CALC).
- IDLE:
  - start=1 at edge E0: latch all four digits into internal registers, acc<=0, step<=0, err<=0, go to CALC.
  - start=0: stay in IDLE.
  - Input digits may change after E0 without effect.
- CALC: one digit per edge, order thousands, hundreds, tens, ones (step 0..3).
  - acc_next = acc*10 + digit[step]. Implement *10 as (acc<<3)+(acc<<1), computed at OUT_W bits; no overflow is possible for valid digits.
  - A digit > 9 is still accumulated, truncated to OUT_W bits; its result is overridden (see err rule).
  - At step 3 (edge E4):
    - valid digits: bin<=acc_next, done<=1, err<=0, state<=IDLE;
    - any latched digit > 9: bin<=0, err<=1, done<=1, state<=IDLE.
- Latency:
  - start sampled at E0; done high for exactly the cycle following E4, i.e. 4 clocks after acceptance.
  - ready is high in that same cycle.
- Back-to-back: start=1 at E5 (while done=1) is accepted.
  - done drops at E5.
  - bin and err keep their previous values until the new conversion completes; err is cleared at accept.
- start while busy (CALC): ignored, no queuing; the current conversion completes unaffected.
- done is a single-cycle pulse and is never held for more than one cycle.
- Reset mid-CALC: immediate return to reset values. A conversion interrupted by reset produces no done pulse.
- Combinational paths from inputs to outputs: none; all outputs are registered or decoded from state.

Test Plan:
- Digits 1,2,3,4 with a start pulse -> done exactly 4 clocks after accept, bin=16'h04D2 (1234), err=0; ready low for 4 cycles.
- Digits 9,9,9,9 -> bin=16'h270F (9999), err=0. Then 0,0,0,0 -> bin=16'h0000, err=0, done pulses once.
- Digits 1,0xA,3,4 -> done after 4 clocks with err=1, bin=16'h0000. Next start with 0,0,5,9 -> err cleared at accept; after done, bin=16'h003B, err=0.
- start held high continuously with digits 2,0,1,5 -> bin=16'h07DF at each done. Conversions repeat every 5 clocks; inputs changed during CALC do not alter the result.
- Start 5,0,0,0, then assert rst_n=0 at the 2nd CALC cycle -> outputs immediately at reset values, no done; after release, start 0,0,4,2 -> bin=16'h002A.
- Extra start pulses during CALC -> ignored; exactly one done per accepted start, and bin holds its value between done pulses.
